// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall control slice.
// Includes the Tuse/Tnew source-hazard predicate used for both rs and rt.
package pipe_pkg;

  typedef logic [1:0] tcnt_t;

  localparam tcnt_t      TUSE_NONE       = 2'd3;
  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         DEF_MULT_CYCLES = 5;
  localparam int         DEF_DIV_CYCLES  = 10;

  // A source stalls when a producer in E or M will not have its result ready in time.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input tcnt_t      tuse,
    input logic [4:0] wa_e,
    input tcnt_t      tnew_e,
    input logic [4:0] wa_m,
    input tcnt_t      tnew_m
  );
    return (tuse != TUSE_NONE) && (src != REG_ZERO) &&
           (((src == wa_e) && (tnew_e > tuse)) || ((src == wa_m) && (tnew_m > tuse)));
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the multi-cycle multiply/divide unit with a down counter.
// Busy is asserted from the issuing cycle until the counter drains.
module md_busy_tracker
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_e,
  input  logic md_is_div_e,
  output logic md_busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MD_W       = $clog2(MAX_CYCLES + 1);

  logic [MD_W-1:0] md_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_start_e) begin
      md_cnt <= md_is_div_e ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  // Reset masks a same-cycle start so busy reads low for the whole reset cycle.
  assign md_busy = ~reset & (md_start_e | (md_cnt != '0));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: data hazards, mult/div
// busy interlock and a saturating stall-cycle counter.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [1:0]       tuse_rs_d,
  input  logic [1:0]       tuse_rt_d,
  input  logic [4:0]       wa_e,
  input  logic [1:0]       tnew_e,
  input  logic [4:0]       wa_m,
  input  logic [1:0]       tnew_m,
  input  logic             md_use_d,
  input  logic             md_start_e,
  input  logic             md_is_div_e,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;

  md_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy (
    .clk        (clk),
    .reset      (reset),
    .md_start_e (md_start_e),
    .md_is_div_e(md_is_div_e),
    .md_busy    (md_busy)
  );

  // NOTE: combinational outputs are continuous assigns, so no path can infer a latch.
  assign stall_rs = src_hazard(rs_d, tuse_rs_d, wa_e, tnew_e, wa_m, tnew_m);
  assign stall_rt = src_hazard(rt_d, tuse_rt_d, wa_e, tnew_e, wa_m, tnew_m);
  assign stall_md = md_use_d & md_busy;
  assign stall    = ~reset & (stall_rs | stall_rt | stall_md);

  assign pc_en    = ~stall;
  assign ifid_en  = ~stall;
  assign idex_clr = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl; a second instance with a
// 3-bit counter covers saturation.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_d, rt_d, wa_e, wa_m;
  logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic        md_use_d, md_start_e, md_is_div_e;
  logic        pc_en, ifid_en, idex_clr, md_busy;
  logic [31:0] stall_cnt;
  logic        pc_en_s, ifid_en_s, idex_clr_s, md_busy_s;
  logic [2:0]  stall_cnt_s;

  int passed = 0;
  int total  = 0;

  pipe_stall_ctrl dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .wa_e(wa_e), .tnew_e(tnew_e), .wa_m(wa_m), .tnew_m(tnew_m),
    .md_use_d(md_use_d), .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_clr(idex_clr),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  pipe_stall_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .wa_e(wa_e), .tnew_e(tnew_e), .wa_m(wa_m), .tnew_m(tnew_m),
    .md_use_d(md_use_d), .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
    .pc_en(pc_en_s), .ifid_en(ifid_en_s), .idex_clr(idex_clr_s),
    .md_busy(md_busy_s), .stall_cnt(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    rs_d = 5'd0; rt_d = 5'd0; tuse_rs_d = 2'd3; tuse_rt_d = 2'd3;
    wa_e = 5'd0; tnew_e = 2'd0; wa_m = 5'd0; tnew_m = 2'd0;
    md_use_d = 1'b0; md_start_e = 1'b0; md_is_div_e = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_ctrl(input string name, input logic exp_stall);
    total++;
    if ({pc_en, ifid_en, idex_clr} !== {~exp_stall, ~exp_stall, exp_stall})
      $display("FAIL %s: pc_en/ifid_en/idex_clr got %b%b%b expected %b%b%b", name,
               pc_en, ifid_en, idex_clr, ~exp_stall, ~exp_stall, exp_stall);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    md_start_e = 1'b1; md_is_div_e = 1'b1; md_use_d = 1'b1;
    rs_d = 5'd8; tuse_rs_d = 2'd0; wa_e = 5'd8; tnew_e = 2'd2;
    @(negedge clk);
    chk_ctrl("reset_ctrl", 1'b0);
    total++;
    if (md_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", md_busy);
    else passed++;
    tick();
    idle();
    reset = 1'b0;
    md_use_d = 1'b1;
    @(negedge clk);
    total++;
    if (md_busy !== 1'b0) $display("FAIL reset_start_same_cycle: md_busy got %b expected 0", md_busy);
    else passed++;
    chk_ctrl("reset_start_no_stall", 1'b0);
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
    else passed++;
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    wa_e = 5'd8; tnew_e = 2'd2; rs_d = 5'd8; tuse_rs_d = 2'd1;
    @(negedge clk);
    chk_ctrl("load_use_stall", 1'b1);
    tick();
    wa_e = 5'd0; tnew_e = 2'd0; wa_m = 5'd8; tnew_m = 2'd1;
    @(negedge clk);
    chk_ctrl("load_use_release", 1'b0);
    total++;
    if (stall_cnt !== 32'd1) $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt);
    else passed++;
    rs_d = 5'd0; tuse_rs_d = 2'd3;
    rt_d = 5'd9; tuse_rt_d = 2'd1; wa_m = 5'd9; tnew_m = 2'd2;
    #1 chk_ctrl("rt_vs_m_stall", 1'b1);
    tnew_m = 2'd1;
    #1 chk_ctrl("rt_vs_m_equal_tnew", 1'b0);
    tick();
  endtask

  task automatic test_no_hazard();
    apply_reset();
    wa_e = 5'd8; tnew_e = 2'd1; rs_d = 5'd8; tuse_rs_d = 2'd1;
    @(negedge clk);
    chk_ctrl("forwardable", 1'b0);
    idle();
    rs_d = 5'd0; tuse_rs_d = 2'd0; wa_e = 5'd0; tnew_e = 2'd2;
    #1 chk_ctrl("reg_zero", 1'b0);
    idle();
    rt_d = 5'd12; tuse_rt_d = 2'd3; wa_e = 5'd12; tnew_e = 2'd2;
    #1 chk_ctrl("rt_not_read", 1'b0);
    tick();
    @(negedge clk);
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL no_hazard_cnt: got %0d expected 0", stall_cnt);
    else passed++;
  endtask

  task automatic test_mult();
    apply_reset();
    md_use_d = 1'b1; md_start_e = 1'b1; md_is_div_e = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      total++;
      if (md_busy !== (c <= 5)) $display("FAIL mult_busy_c%0d: got %b expected %b", c, md_busy, c <= 5);
      else passed++;
      chk_ctrl($sformatf("mult_stall_c%0d", c), c <= 5);
      tick();
      md_start_e = 1'b0;
    end
    @(negedge clk);
    total++;
    if (stall_cnt !== 32'd6) $display("FAIL mult_cnt: got %0d expected 6", stall_cnt);
    else passed++;
  endtask

  task automatic test_div();
    apply_reset();
    md_start_e = 1'b1; md_is_div_e = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      total++;
      if (md_busy !== (c <= 10)) $display("FAIL div_busy_c%0d: got %b expected %b", c, md_busy, c <= 10);
      else passed++;
      chk_ctrl($sformatf("div_no_stall_c%0d", c), 1'b0);
      tick();
      md_start_e = 1'b0;
    end
    @(negedge clk);
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL div_cnt: got %0d expected 0", stall_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    md_start_e = 1'b1; md_is_div_e = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      md_start_e = (c == 0) || (c == 2);
      md_is_div_e = (c == 2);
      @(negedge clk);
      total++;
      if (md_busy !== (c <= 12)) $display("FAIL reload_busy_c%0d: got %b expected %b", c, md_busy, c <= 12);
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid_div();
    apply_reset();
    md_use_d = 1'b1; md_start_e = 1'b1; md_is_div_e = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      md_start_e = 1'b0;
    end
    @(negedge clk);
    total++;
    if (stall_cnt !== 32'd4) $display("FAIL mid_div_cnt_before: got %0d expected 4", stall_cnt);
    else passed++;
    reset = 1'b1;
    #1 chk_ctrl("mid_div_reset_ctrl", 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (md_busy !== 1'b0) $display("FAIL mid_div_busy_after: got %b expected 0", md_busy);
    else passed++;
    chk_ctrl("mid_div_no_stall_after", 1'b0);
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL mid_div_cnt_after: got %0d expected 0", stall_cnt);
    else passed++;
  endtask

  task automatic test_saturation();
    apply_reset();
    wa_e = 5'd3; tnew_e = 2'd2; rs_d = 5'd3; tuse_rs_d = 2'd0;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      total++;
      if (stall_cnt_s !== 3'((k > 7) ? 7 : k))
        $display("FAIL sat_cnt_k%0d: got %0d expected %0d", k, stall_cnt_s, (k > 7) ? 7 : k);
      else passed++;
      total++;
      if (stall_cnt !== 32'(k)) $display("FAIL wide_cnt_k%0d: got %0d expected %0d", k, stall_cnt, k);
      else passed++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
